// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, control bundle and FSM encodings for pipe_ctrl_unit
package ctrl_pkg;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        ALU_R   = 3'd0,
        ALU_I   = 3'd1,
        ALU_BR  = 3'd2,
        ALU_JMP = 3'd3,
        ALU_LD  = 3'd4,
        ALU_ST  = 3'd5,
        ALU_UI  = 3'd6
    } aluop_e;

    typedef struct packed {
        aluop_e     aluop;
        logic [1:0] opasel;
        logic       opbsel;
        logic [1:0] extsel;
        logic [1:0] nextpc;
        logic       memw;
        logic       memrd;
        logic       regwrite;
        logic       memtoreg;
        logic       branch;
    } ctrl_t;

    // All-zero bundle: what a bubble carries down the pipe.
    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HAZ  = 2'd1,
        HOLD = 2'd2
    } fsm_e;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode decoder producing the control bundle and rs usage
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       use_rs1_o,
    output logic       use_rs2_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_NOP;
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_R: begin
                ctrl_o.aluop    = ALU_R;
                ctrl_o.regwrite = 1'b1;
                use_rs1_o       = 1'b1;
                use_rs2_o       = 1'b1;
            end
            OPC_I: begin
                ctrl_o.aluop    = ALU_I;
                ctrl_o.opbsel   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                use_rs1_o       = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.aluop    = ALU_LD;
                ctrl_o.opbsel   = 1'b1;
                ctrl_o.memrd    = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                use_rs1_o       = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.aluop  = ALU_ST;
                ctrl_o.opbsel = 1'b1;
                ctrl_o.extsel = 2'b10;
                ctrl_o.memw   = 1'b1;
                use_rs1_o     = 1'b1;
                use_rs2_o     = 1'b1;
            end
            OPC_BR: begin
                ctrl_o.aluop  = ALU_BR;
                ctrl_o.nextpc = 2'b01;
                ctrl_o.branch = 1'b1;
                use_rs1_o     = 1'b1;
                use_rs2_o     = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.aluop    = ALU_JMP;
                ctrl_o.opasel   = 2'b10;
                ctrl_o.nextpc   = 2'b11;
                ctrl_o.regwrite = 1'b1;
                use_rs1_o       = 1'b1;
            end
            OPC_JAL: begin
                ctrl_o.aluop    = ALU_JMP;
                ctrl_o.opasel   = 2'b10;
                ctrl_o.nextpc   = 2'b10;
                ctrl_o.regwrite = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                ctrl_o.aluop    = ALU_UI;
                ctrl_o.opasel   = 2'b11;
                ctrl_o.opbsel   = 1'b1;
                ctrl_o.extsel   = 2'b01;
                ctrl_o.regwrite = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined RV32 control: ID decode, EX/MEM/WB bundles, hazard, flush, freeze
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter bit HAZARD_EN    = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_valid_i,
    input  logic [31:0]       instr_i,
    output logic              id_ready_o,
    input  logic              freeze_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [2:0]        ex_aluop_o,
    output logic [1:0]        ex_opasel_o,
    output logic              ex_opbsel_o,
    output logic [1:0]        ex_extsel_o,
    output logic [1:0]        ex_nextpc_o,
    output logic              ex_branch_o,
    output logic              mem_memw_o,
    output logic              mem_memrd_o,
    output logic              wb_regwrite_o,
    output logic              wb_memtoreg_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic              illegal_o
);

    ctrl_t             id_ctrl;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_illegal;
    logic [REG_AW-1:0] id_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              unused_instr;

    logic              ex_valid_q;
    ctrl_t             ex_ctrl_q;
    logic [REG_AW-1:0] ex_rd_q;

    logic              mem_valid_q;
    logic              mem_memw_q;
    logic              mem_memrd_q;
    logic              mem_regwrite_q;
    logic              mem_memtoreg_q;
    logic [REG_AW-1:0] mem_rd_q;

    logic              wb_valid_q;
    logic              wb_regwrite_q;
    logic              wb_memtoreg_q;
    logic [REG_AW-1:0] wb_rd_q;

    logic              illegal_q;
    fsm_e              state_q;
    fsm_e              state_d;
    fsm_e              prev_q;
    fsm_e              prev_d;

    logic              hazard;
    logic              advance;
    logic              ready_fsm;
    logic              accept;

    assign id_rd        = instr_i[7 +: REG_AW];
    assign id_rs1       = instr_i[15 +: REG_AW];
    assign id_rs2       = instr_i[20 +: REG_AW];
    assign unused_instr = ^instr_i;

    ctrl_decode u_decode (
        .opcode_i  (instr_i[6:0]),
        .ctrl_o    (id_ctrl),
        .use_rs1_o (id_use_rs1),
        .use_rs2_o (id_use_rs2),
        .illegal_o (id_illegal)
    );

    // Only a load in EX can still be short of its result when ID needs it.
    assign hazard = HAZARD_EN && instr_valid_i && ex_valid_q && ex_ctrl_q.memrd
                    && (ex_rd_q != '0)
                    && ((id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd_q)));

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        advance   = 1'b0;
        ready_fsm = 1'b0;
        if (freeze_i) begin
            state_d = HOLD;
            if (state_q != HOLD) begin
                prev_d = state_q;
            end
        end else begin
            advance   = 1'b1;
            ready_fsm = !flush_i && !hazard;
            if (flush_i) begin
                state_d = RUN;
            end else if (hazard) begin
                state_d = HAZ;
            end else if (state_q == HOLD) begin
                state_d = prev_q;
            end else begin
                state_d = RUN;
            end
        end
    end

    assign id_ready_o = !rst_i && ready_fsm;
    assign accept     = instr_valid_i && id_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            prev_q         <= RUN;
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= CTRL_NOP;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_memw_q     <= 1'b0;
            mem_memrd_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memtoreg_q <= 1'b0;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_rd_q        <= '0;
            illegal_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            illegal_q <= 1'b0;
            if (advance) begin
                wb_valid_q     <= mem_valid_q;
                wb_regwrite_q  <= mem_regwrite_q;
                wb_memtoreg_q  <= mem_memtoreg_q;
                wb_rd_q        <= mem_rd_q;
                mem_valid_q    <= ex_valid_q;
                mem_memw_q     <= ex_ctrl_q.memw;
                mem_memrd_q    <= ex_ctrl_q.memrd;
                mem_regwrite_q <= ex_ctrl_q.regwrite;
                mem_memtoreg_q <= ex_ctrl_q.memtoreg;
                mem_rd_q       <= ex_rd_q;
                // Illegal opcodes are consumed but travel on as a bubble.
                if (accept && !id_illegal) begin
                    ex_valid_q <= 1'b1;
                    ex_ctrl_q  <= id_ctrl;
                    ex_rd_q    <= id_rd;
                end else begin
                    ex_valid_q <= 1'b0;
                    ex_ctrl_q  <= CTRL_NOP;
                    ex_rd_q    <= '0;
                end
                illegal_q <= ILLEGAL_TRAP && accept && id_illegal;
            end
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_aluop_o    = ex_valid_q ? ex_ctrl_q.aluop  : 3'b000;
    assign ex_opasel_o   = ex_valid_q ? ex_ctrl_q.opasel : 2'b00;
    assign ex_opbsel_o   = ex_valid_q && ex_ctrl_q.opbsel;
    assign ex_extsel_o   = ex_valid_q ? ex_ctrl_q.extsel : 2'b00;
    assign ex_nextpc_o   = ex_valid_q ? ex_ctrl_q.nextpc : 2'b00;
    assign ex_branch_o   = ex_valid_q && ex_ctrl_q.branch;
    assign mem_memw_o    = mem_valid_q && mem_memw_q;
    assign mem_memrd_o   = mem_valid_q && mem_memrd_q;
    assign wb_regwrite_o = wb_valid_q && wb_regwrite_q && (wb_rd_q != '0);
    assign wb_memtoreg_o = wb_valid_q && wb_memtoreg_q;
    assign wb_rd_o       = wb_valid_q ? wb_rd_q : '0;
    assign illegal_o     = illegal_q;

endmodule
